// File: rtl/fft_pkg.sv
// fft_stream_checker shared package: FSM state enum, lane
// pack/unpack helpers and a constant-time clog2.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Widest packed word the lane helpers handle.
  localparam int MAX_W = 256;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_bits(input int v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

  // Raw component of lane k: real is the upper half of the
  // lane, imag the lower. Result is zero-extended.
  function automatic logic [31:0] lane_get(
    input logic [MAX_W-1:0] data,
    input int               nbits,
    input int               k,
    input logic             im
  );
    logic [MAX_W-1:0] s;
    logic [31:0]      m;
    s = data >> (k * 2 * nbits + (im ? 0 : nbits));
    m = (32'd1 << nbits) - 32'd1;
    return s[31:0] & m;
  endfunction

  function automatic logic [MAX_W-1:0] lane_put(
    input logic [MAX_W-1:0] data,
    input int               nbits,
    input int               k,
    input logic             im,
    input logic [31:0]      v
  );
    int               lo;
    logic [MAX_W-1:0] m;
    lo = k * 2 * nbits + (im ? 0 : nbits);
    m  = MAX_W'((64'd1 << nbits) - 64'd1) << lo;
    return (data & ~m) | ((MAX_W'(v) << lo) & m);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Expected-word FIFO: push/pop self-gated by full/empty, flags
// from a count register, synchronous active-low rst flush.
module sync_fifo
  import fft_pkg::*;
#(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fft_stream_checker.sv
// Self-checking comparator for parallel FFT output lanes.
// Ports: start/num_frames/skip_words arm a run; exp_* feeds the
// expected FIFO; dut_* is compared per lane within TOL; status
// outputs busy/done/mismatch*/err_count/first_err_*/ovf/unf.
module fft_stream_checker
  import fft_pkg::*;
#(
  parameter int NBITS_OUT = 10,
  parameter int LANES     = 4,
  parameter int N         = 128,
  parameter int DEPTH     = 16,
  parameter int TOL       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [15:0]                     num_frames,
  input  logic [7:0]                      skip_words,
  input  logic                            exp_valid,
  input  logic [LANES*2*NBITS_OUT-1:0]    exp_data,
  output logic                            exp_ready,
  input  logic                            dut_valid,
  input  logic [LANES*2*NBITS_OUT-1:0]    dut_data,
  output logic                            busy,
  output logic                            done,
  output logic                            mismatch,
  output logic [LANES-1:0]                mismatch_lanes,
  output logic [15:0]                     err_count,
  output logic                            first_err_valid,
  output logic [15:0]                     first_err_frame,
  output logic [cnt_bits(N/LANES)-1:0]    first_err_word,
  output logic                            ovf,
  output logic                            unf
);

  localparam int DW = LANES * 2 * NBITS_OUT;
  localparam int W  = N / LANES;
  localparam int WB = cnt_bits(W);
  localparam logic [NBITS_OUT:0] TOL_V = (NBITS_OUT + 1)'(TOL);

  state_t           state;
  logic [7:0]       skip_cnt;
  logic [WB-1:0]    word_cnt;
  logic [15:0]      frame_cnt;
  logic [15:0]      frames_tgt;
  logic [DW-1:0]    exp_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LANES-1:0] lane_fail;
  logic [LANES-1:0] cmp_lanes;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (exp_valid),
    .pop   ((state == ST_CHECK) && dut_valid),
    .wdata (exp_data),
    .rdata (exp_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign exp_ready = !fifo_full;
  assign busy = (state == ST_SKIP) || (state == ST_CHECK);

  // One extra bit keeps the difference of two full-range
  // components from wrapping into a small value.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [NBITS_OUT-1:0]        er;
    logic [NBITS_OUT-1:0]        ei;
    logic [NBITS_OUT-1:0]        dr;
    logic [NBITS_OUT-1:0]        di;
    logic signed [NBITS_OUT:0]   d_re;
    logic signed [NBITS_OUT:0]   d_im;
    logic [NBITS_OUT:0]          a_re;
    logic [NBITS_OUT:0]          a_im;

    assign er = NBITS_OUT'(lane_get(MAX_W'(exp_word), NBITS_OUT, k, 1'b0));
    assign ei = NBITS_OUT'(lane_get(MAX_W'(exp_word), NBITS_OUT, k, 1'b1));
    assign dr = NBITS_OUT'(lane_get(MAX_W'(dut_data), NBITS_OUT, k, 1'b0));
    assign di = NBITS_OUT'(lane_get(MAX_W'(dut_data), NBITS_OUT, k, 1'b1));

    assign d_re = $signed({dr[NBITS_OUT-1], dr})
                - $signed({er[NBITS_OUT-1], er});
    assign d_im = $signed({di[NBITS_OUT-1], di})
                - $signed({ei[NBITS_OUT-1], ei});

    assign a_re = d_re[NBITS_OUT] ? $unsigned(-d_re) : $unsigned(d_re);
    assign a_im = d_im[NBITS_OUT] ? $unsigned(-d_im) : $unsigned(d_im);

    assign lane_fail[k] = (a_re > TOL_V) || (a_im > TOL_V);
  end

  // A DUT word with nothing to compare against fails every lane.
  assign cmp_lanes = fifo_empty ? '1 : lane_fail;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      skip_cnt        <= '0;
      word_cnt        <= '0;
      frame_cnt       <= '0;
      frames_tgt      <= '0;
      done            <= 1'b0;
      mismatch        <= 1'b0;
      mismatch_lanes  <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_frame <= '0;
      first_err_word  <= '0;
      ovf             <= 1'b0;
      unf             <= 1'b0;
    end else begin
      done           <= 1'b0;
      mismatch       <= 1'b0;
      mismatch_lanes <= '0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_frame <= '0;
            first_err_word  <= '0;
            ovf             <= 1'b0;
            unf             <= 1'b0;
            word_cnt        <= '0;
            frame_cnt       <= '0;
            frames_tgt      <= num_frames;
            skip_cnt        <= skip_words;
            if (num_frames == 16'd0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (skip_words != 8'd0) begin
              state <= ST_SKIP;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_SKIP: begin
          if (dut_valid) begin
            skip_cnt <= skip_cnt - 8'd1;
            if (skip_cnt == 8'd1) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (dut_valid) begin
            mismatch       <= |cmp_lanes;
            mismatch_lanes <= cmp_lanes;
            if (fifo_empty) unf <= 1'b1;
            if (|cmp_lanes) begin
              if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_frame <= frame_cnt;
                first_err_word  <= word_cnt;
              end
            end
            if (word_cnt == WB'(W - 1)) begin
              word_cnt <= '0;
              if (frame_cnt == frames_tgt - 16'd1) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 16'd1;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A dropped push is flagged even on the cycle start clears.
      if (exp_valid && fifo_full) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_stream_checker.sv
// Directed bench for fft_stream_checker: TOL=0 and TOL=1
// instances share all stimulus; each task checks inline.
module tb_fft_stream_checker;
  import fft_pkg::*;

  localparam int NB  = 10;
  localparam int WPF = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_frames;
  logic [7:0]  skip_words;
  logic        exp_valid;
  logic [79:0] exp_data;
  logic        dut_valid;
  logic [79:0] dut_data;

  logic        exp_ready, busy, done, mismatch;
  logic [3:0]  mismatch_lanes;
  logic [15:0] err_count, first_err_frame;
  logic        first_err_valid, ovf, unf;
  logic [4:0]  first_err_word;

  logic        exp_ready_t, busy_t, done_t, mismatch_t;
  logic [3:0]  mismatch_lanes_t;
  logic [15:0] err_count_t, first_err_frame_t;
  logic        first_err_valid_t, ovf_t, unf_t;
  logic [4:0]  first_err_word_t;

  int n_chk = 0;
  int n_fail = 0;
  int done_j0, done_j1;
  logic [3:0] ml0 [64];
  logic [3:0] ml1 [64];

  always #5 clk = ~clk;

  fft_stream_checker #(.TOL(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_frames(num_frames), .skip_words(skip_words),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(exp_ready),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .busy(busy), .done(done), .mismatch(mismatch),
    .mismatch_lanes(mismatch_lanes), .err_count(err_count),
    .first_err_valid(first_err_valid),
    .first_err_frame(first_err_frame),
    .first_err_word(first_err_word), .ovf(ovf), .unf(unf)
  );

  fft_stream_checker #(.TOL(1)) dut_t (
    .clk(clk), .rst(rst), .start(start),
    .num_frames(num_frames), .skip_words(skip_words),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(exp_ready_t),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .busy(busy_t), .done(done_t), .mismatch(mismatch_t),
    .mismatch_lanes(mismatch_lanes_t), .err_count(err_count_t),
    .first_err_valid(first_err_valid_t),
    .first_err_frame(first_err_frame_t),
    .first_err_word(first_err_word_t), .ovf(ovf_t), .unf(unf_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] wd(input int i);
    logic [MAX_W-1:0] t;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      t = lane_put(t, NB, k, 1'b0, 32'((i * 37 + k * 101) & 1023));
      t = lane_put(t, NB, k, 1'b1, 32'((i * 53 + k * 29 + 5) & 1023));
    end
    return 80'(t);
  endfunction

  function automatic logic [79:0] setc(
    input logic [79:0] w, input int k, input logic [31:0] v);
    return 80'(lane_put(MAX_W'(w), NB, k, 1'b0, v));
  endfunction

  // mode 1: lane 2 real forced to 100 at words 3 and 37
  // mode 2: lane 0 real = -512 at word 10
  function automatic logic [79:0] ex_w(input int j, input int mode);
    logic [79:0] w;
    w = wd(j);
    if (mode == 1 && (j == 3 || j == 37)) w = setc(w, 2, 32'd100);
    if (mode == 2 && j == 10) w = setc(w, 0, 32'h200);
    return w;
  endfunction

  function automatic logic [79:0] du_w(input int j, input int mode);
    logic [79:0] w;
    w = ex_w(j, mode);
    if (mode == 1 && j == 3)  w = setc(w, 2, 32'd101);
    if (mode == 1 && j == 37) w = setc(w, 2, 32'd98);
    if (mode == 2 && j == 10) w = setc(w, 0, 32'h1FF);
    return w;
  endfunction

  // Expected word c is pushed one cycle before DUT word c.
  task automatic run(input int nf, input int skip, input int mode);
    int n;
    n = nf * WPF;
    done_j0 = -1;
    done_j1 = -1;
    num_frames = 16'(nf);
    skip_words = 8'(skip);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < skip; s++) begin
      dut_valid = 1'b1;
      dut_data = ~wd(s + 500);
      tick();
    end
    dut_valid = 1'b0;
    for (int c = 0; c <= n; c++) begin
      exp_valid = (c < n);
      exp_data = ex_w(c, mode);
      dut_valid = (c >= 1);
      dut_data = du_w(c - 1, mode);
      tick();
      if (c >= 1) begin
        ml0[c-1] = mismatch_lanes;
        ml1[c-1] = mismatch_lanes_t;
        if (done && done_j0 < 0) done_j0 = c - 1;
        if (done_t && done_j1 < 0) done_j1 = c - 1;
      end
    end
    exp_valid = 1'b0;
    dut_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_chk++;
    if (done !== 1'b0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b/%b want 0/0", done, mismatch);
    end
    n_chk++;
    if (err_count !== 16'd0 || first_err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %0d/%b want 0/0",
               err_count, first_err_valid);
    end
    n_chk++;
    if (exp_ready !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fifo rdy/ovf/unf got %b%b%b want 100",
               exp_ready, ovf, unf);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_frames();
    num_frames = 16'd0;
    skip_words = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_frames done/busy got %b/%b want 1/0",
               done, busy);
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_frames_pulse got %b want 0", done);
    end
  endtask

  task automatic test_exact();
    logic [3:0] any;
    run(2, 0, 0);
    any = '0;
    for (int j = 0; j < 64; j++) any = any | ml0[j];
    n_chk++;
    if (done_j0 !== 63) begin
      n_fail++;
      $display("FAIL exact_done_word got %0d want 63", done_j0);
    end
    n_chk++;
    if (err_count !== 16'd0 || first_err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_err got %0d/%b want 0/0",
               err_count, first_err_valid);
    end
    n_chk++;
    if (any !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_lanes/busy got %h/%b want 0/0", any, busy);
    end
  endtask

  task automatic test_skip();
    run(1, 7, 0);
    n_chk++;
    if (done_j0 !== 31) begin
      n_fail++;
      $display("FAIL skip_done_word got %0d want 31", done_j0);
    end
    n_chk++;
    if (err_count !== 16'd0 || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_err got %0d/%b want 0/0", err_count, unf);
    end
    n_chk++;
    if (dut.u_fifo.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_fifo_empty got %b want 1", dut.u_fifo.empty);
    end
  endtask

  task automatic test_tolerance();
    run(2, 0, 1);
    n_chk++;
    if (ml1[3] !== 4'b0000) begin
      n_fail++;
      $display("FAIL tol_plus1 got %b want 0000", ml1[3]);
    end
    n_chk++;
    if (ml1[37] !== 4'b0100) begin
      n_fail++;
      $display("FAIL tol_minus2 got %b want 0100", ml1[37]);
    end
    n_chk++;
    if (err_count_t !== 16'd1 || first_err_valid_t !== 1'b1) begin
      n_fail++;
      $display("FAIL tol_count got %0d/%b want 1/1",
               err_count_t, first_err_valid_t);
    end
    n_chk++;
    if (first_err_frame_t !== 16'd1 || first_err_word_t !== 5'd5) begin
      n_fail++;
      $display("FAIL tol_loc got f%0d w%0d want f1 w5",
               first_err_frame_t, first_err_word_t);
    end
    n_chk++;
    if (ml0[3] !== 4'b0100 || err_count !== 16'd2) begin
      n_fail++;
      $display("FAIL exact_tol0 got %b/%0d want 0100/2",
               ml0[3], err_count);
    end
    n_chk++;
    if (first_err_frame !== 16'd0 || first_err_word !== 5'd3) begin
      n_fail++;
      $display("FAIL tol0_loc got f%0d w%0d want f0 w3",
               first_err_frame, first_err_word);
    end
    n_chk++;
    if (done_j1 !== 63) begin
      n_fail++;
      $display("FAIL tol_done_word got %0d want 63", done_j1);
    end
  endtask

  task automatic test_sign();
    run(1, 0, 2);
    n_chk++;
    if (ml0[10] !== 4'b0001 || err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL sign_tol0 got %b/%0d want 0001/1",
               ml0[10], err_count);
    end
    n_chk++;
    if (ml1[10] !== 4'b0001 || err_count_t !== 16'd1) begin
      n_fail++;
      $display("FAIL sign_wrap got %b/%0d want 0001/1",
               ml1[10], err_count_t);
    end
  endtask

  task automatic test_fifo();
    logic [3:0] any;
    for (int i = 0; i < 16; i++) begin
      exp_valid = 1'b1;
      exp_data = wd(i);
      tick();
    end
    n_chk++;
    if (exp_ready !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full rdy/ovf got %b/%b want 0/0",
               exp_ready, ovf);
    end
    exp_data = wd(99);
    tick();
    exp_valid = 1'b0;
    n_chk++;
    if (ovf !== 1'b1 || exp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_ovf ovf/rdy got %b/%b want 1/0",
               ovf, exp_ready);
    end
    num_frames = 16'd1;
    skip_words = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (ovf !== 1'b0 || exp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start_keeps_fifo ovf/rdy got %b/%b want 0/0",
               ovf, exp_ready);
    end
    any = '0;
    for (int j = 0; j < 16; j++) begin
      dut_valid = 1'b1;
      dut_data = wd(j);
      tick();
      any = any | mismatch_lanes;
    end
    n_chk++;
    if (any !== 4'd0 || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL preload got %b/%b want 0000/0", any, unf);
    end
    dut_data = wd(16);
    tick();
    n_chk++;
    if (unf !== 1'b1 || mismatch_lanes !== 4'hF || mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL unf got unf=%b lanes=%h mm=%b want 1 f 1",
               unf, mismatch_lanes, mismatch);
    end
    n_chk++;
    if (err_count !== 16'd1 || first_err_word !== 5'd16) begin
      n_fail++;
      $display("FAIL unf_count got %0d w%0d want 1 w16",
               err_count, first_err_word);
    end
    for (int j = 17; j < 32; j++) begin
      dut_data = wd(j);
      tick();
    end
    dut_valid = 1'b0;
    n_chk++;
    if (done !== 1'b1 || err_count !== 16'd16) begin
      n_fail++;
      $display("FAIL unf_done got %b/%0d want 1/16", done, err_count);
    end
  endtask

  task automatic test_reset_mid();
    num_frames = 16'd2;
    skip_words = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      exp_valid = 1'b1;
      exp_data = wd(c);
      dut_valid = (c >= 1);
      dut_data = ~wd(c - 1);
      if (c == 20) rst = 1'b0;
      tick();
      if (c == 19) begin
        n_chk++;
        if (err_count !== 16'd19 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_pre got %0d/%b want 19/1", err_count, busy);
        end
      end
    end
    exp_valid = 1'b0;
    dut_valid = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || err_count !== 16'd0 || exp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst busy/err/rdy got %b/%0d/%b want 0/0/1",
               busy, err_count, exp_ready);
    end
    n_chk++;
    if (first_err_valid !== 1'b0 || dut.u_fifo.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_flush fev/empty got %b/%b want 0/1",
               first_err_valid, dut.u_fifo.empty);
    end
    rst = 1'b1;
    tick();
    run(2, 0, 0);
    n_chk++;
    if (done_j0 !== 63 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_rerun got word %0d err %0d want 63/0",
               done_j0, err_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    num_frames = '0;
    skip_words = '0;
    exp_valid = 1'b0;
    exp_data = '0;
    dut_valid = 1'b0;
    dut_data = '0;
    test_reset();
    test_zero_frames();
    test_exact();
    test_skip();
    test_tolerance();
    test_sign();
    test_fifo();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_stream_checker.md
# fft_stream_checker

Synthesisable, parametrised self-checking comparator for the parallel FFT output streams. It replaces the fixed-delay file-alignment scheme with a handshaked expected-data FIFO, a programmable pipeline-fill skip, per-lane tolerance compare, frame and word tracking, and first-error capture. It sits beside `topfft` in both the bench and the on-board test harness. The expected stream comes from a ROM or loader; the DUT stream taps the `fftOut*` lanes.

## Interface
- `NBITS_OUT`, 10: bits per real/imag component, two's complement.
- `LANES`, 4: complex samples per word. Lane k occupies bits [(k+1)*2*NBITS_OUT-1 : k*2*NBITS_OUT], with real in the upper half and imag in the lower.
- `N`, 128: FFT length in samples. Words per frame W = N/LANES; N must be a multiple of LANES.
- `DEPTH`, 16: expected FIFO depth, power of 2.
- `TOL`, 0: max allowed |dut−exp| per component. 0 means exact match.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that arms a run. Ignored while `busy`.
- `num_frames` in 16: frames to check; sampled on `start`.
- `skip_words` in 8: leading DUT words to discard; sampled on `start`.
- `exp_valid` in 1, `exp_data` in LANES*2*NBITS_OUT: expected word.
- `exp_ready` out 1: equals !full.
- `dut_valid` in 1, `dut_data` in LANES*2*NBITS_OUT: DUT word. No backpressure.
- `busy` out 1: state is SKIP or CHECK.
- `done` out 1: one-cycle pulse when a run completes.
- `mismatch` out 1, `mismatch_lanes` out LANES: registered per-word result.
- `err_count` out 16: mismatching words, saturates at 0xFFFF.
- `first_err_valid` out 1, `first_err_frame` out 16, `first_err_word` out clog2(W): location of the first error.
- `ovf` out 1, `unf` out 1: sticky FIFO overflow and underflow flags.

## Operation
- States: IDLE, SKIP, CHECK, DONE.
  - IDLE/DONE + `start`: go to SKIP if skip_words≠0, else CHECK. If num_frames=0, go to DONE instead and pulse `done`.
  - SKIP: each `dut_valid` decrements the skip counter; the FIFO is not popped. At 0, go to CHECK.
  - CHECK: each `dut_valid` pops the FIFO and compares. After word W−1 of frame num_frames−1, go to DONE.
  - DONE is held until the next `start`.
- `start` clears `err_count`, `first_err_*`, `ovf`, `unf`, and the word and frame counters. It does not flush the FIFO, so the expected stream may be preloaded.
- Compare, per lane and component: sign-extend both operands to NBITS_OUT+1 bits, subtract, take the absolute value. The lane fails if either |Δre| or |Δim| exceeds TOL. `mismatch_lanes[k]` is set for each failing lane; `mismatch` is the OR of `mismatch_lanes`.
- Underflow: `dut_valid` in CHECK with the FIFO empty sets `unf`, counts as a mismatch with `mismatch_lanes` all ones, and advances the counters. There is no same-cycle bypass from push to pop.
- Overflow: `exp_valid` while full sets `ovf` and drops the word, even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy is unchanged.
- The `first_err_*` fields latch only on the first mismatch after `start`.
- The FIFO accepts pushes in every state. Pops happen only in CHECK.
- When `rst`=0 at any clock edge (mid-run included):
  - state goes to IDLE and the FIFO is flushed;
  - all outputs are 0 except `exp_ready`=1.

## Timing
- `mismatch`, `mismatch_lanes`, `err_count`, and `first_err_*` update 1 cycle after the `dut_valid` that caused them. `mismatch` is 0 on cycles with no compare.
- `done` pulses 1 cycle after the final compare. `busy` falls on that same cycle.
- `exp_ready` is combinational from FIFO occupancy.
- `unf` and `ovf` are set 1 cycle after the offending event.
- Sustained throughput is 1 word/cycle.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum;
  - the lane pack/unpack functions (re/im slice of lane k);
  - the `clog2` helper.
- Sub-module `sync_fifo` (parametrised WIDTH, DEPTH), with full/empty flags derived from a count register.
- Compare, counters, and FSM live in the top.

## Test plan
- Exact match: LANES=4, N=128, TOL=0, num_frames=2, skip_words=0, 64 identical words → `err_count`=0, `first_err_valid`=0, `done` 1 cycle after the 64th word.
- Pipeline skip: skip_words=7, 7 garbage DUT words, then 32 matching words → `err_count`=0 and the FIFO is empty at `done`.
- Tolerance: TOL=1, lane 2 real off by +1 → no error. Lane 2 real off by −2 in frame 1, word 5 → `mismatch_lanes`=4'b0100, `first_err_frame`=1, `first_err_word`=5, `err_count`=1.
- Sign extremes: exp re=−512, dut re=+511, TOL=0 → mismatch, with no wrap-around false pass.
- FIFO boundaries: push 17 words with DEPTH=16 → `ovf`=1 and `exp_ready`=0 at 16 words. A `dut_valid` in CHECK with the FIFO empty → `unf`=1 and `mismatch_lanes`=4'hF.
- Reset mid-run: `rst`=0 at word 20 of a 2-frame run → `busy`=0, `err_count`=0, `exp_ready`=1. A following `start` completes normally.
